// File: rtl/wave_pkg.sv
// Purpose: shared encodings for the waveform capture buffer: modes, FSM states, trigger polarity.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wave_pkg;

  // Board switch sw[1:0] mode selection
  localparam logic [1:0] MODE_RUN    = 2'b00;
  localparam logic [1:0] MODE_SINGLE = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;
  localparam logic [1:0] MODE_CLR    = 2'b11;

  // Board switch sw[2] trigger polarity
  localparam logic POL_RISE = 1'b0;
  localparam logic POL_FALL = 1'b1;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_ARMED = 3'd1,
    ST_CAPT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_CLR   = 3'd5
  } state_t;

  // State a mode lands in when it is freshly selected (or out of reset).
  function automatic state_t mode_entry_state(input logic [1:0] mode);
    state_t st;
    case (mode)
      MODE_RUN:    st = ST_RUN;
      MODE_SINGLE: st = ST_ARMED;
      MODE_HOLD:   st = ST_HOLD;
      default:     st = ST_CLR;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/sample_prescaler.sv
// Purpose: sample-rate divider; o_strobe pulses once every i_div+1 clocks.
// Latency: combinational strobe from the counter register; i_div changes act on the next compare.
// Backpressure: none; i_clr holds the counter at zero and suppresses the strobe.
// Ports: i_clk, i_rst (sync, active-high), i_clr (hold counter at 0), i_div, o_strobe.
module sample_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_strobe
);

  logic [DIV_W-1:0] r_cnt;

  // >= rather than == so that lowering i_div below the running count
  // strobes on the very next clock instead of waiting for a wrap.
  assign o_strobe = !i_clr && (r_cnt >= i_div);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (o_strobe) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/wave_capture.sv
// Purpose: multi-channel circular waveform capture with run / single-shot / hold / clear modes.
// Latency: a sample written on a strobe edge is visible on o_wave_form the next cycle.
// Backpressure: none; the buffer is always readable, writes are paced only by the prescaler.
// Ports: i_clk, i_rst (sync, active-high), i_sw[1:0] mode / [2] trigger polarity / [3] re-arm,
//        i_sample_in (bit 0 = trigger channel), i_div (strobe every i_div+1 clocks),
//        o_wave_form (slot k at [k*CH +: CH]), o_wr_ptr, o_capturing, o_done.
module wave_capture
  import wave_pkg::*;
#(
  parameter  int DEPTH = 20,
  parameter  int CH    = 1,
  parameter  int DIV_W = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [3:0]          i_sw,
  input  logic [CH-1:0]       i_sample_in,
  input  logic [DIV_W-1:0]    i_div,
  output logic [DEPTH*CH-1:0] o_wave_form,
  output logic [PTR_W-1:0]    o_wr_ptr,
  output logic                o_capturing,
  output logic                o_done
);

  logic [DEPTH*CH-1:0] r_wave;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic                r_prev_trig;
  logic                r_sw3_d;
  logic                r_done;
  logic                r_capturing;
  state_t              r_state;

  logic [1:0]          w_mode;
  logic                w_strobe;
  logic                w_trig;
  logic                w_rearm;
  logic                w_ptr_last;
  logic [PTR_W-1:0]    w_ptr_inc;
  state_t              w_next_state;
  logic [PTR_W-1:0]    w_next_ptr;
  logic                w_next_done;
  logic                w_we;
  logic                w_clr;

  assign w_mode = i_sw[1:0];

  sample_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (w_clr),
    .i_div    (i_div),
    .o_strobe (w_strobe)
  );

  // Edge detection only looks at strobe-aligned samples, so the trigger
  // sees the same decimated signal that ends up in the buffer.
  always_comb begin
    w_trig = 1'b0;
    if (w_strobe) begin
      if (i_sw[2] == POL_RISE) w_trig = !r_prev_trig && i_sample_in[0];
      else                     w_trig = r_prev_trig && !i_sample_in[0];
    end
  end

  assign w_rearm    = i_sw[3] && !r_sw3_d;
  assign w_ptr_last = (r_wr_ptr == PTR_W'(DEPTH - 1));
  assign w_ptr_inc  = w_ptr_last ? '0 : r_wr_ptr + PTR_W'(1);

  // Next-state logic. The current mode is decoded first so that a mode change
  // overrides whatever the previous state would have done this clock.
  always_comb begin
    w_next_state = r_state;
    w_next_ptr   = r_wr_ptr;
    w_next_done  = r_done;
    w_we         = 1'b0;
    w_clr        = 1'b0;

    case (w_mode)
      MODE_RUN: begin
        w_next_state = ST_RUN;
        w_next_done  = 1'b0;
        if (w_strobe) begin
          w_we       = 1'b1;
          w_next_ptr = w_ptr_inc;
        end
      end

      MODE_SINGLE: begin
        if (r_state != ST_ARMED && r_state != ST_CAPT && r_state != ST_DONE) begin
          // Freshly selected: start a new single shot from slot 0.
          w_next_state = ST_ARMED;
          w_next_ptr   = '0;
          w_next_done  = 1'b0;
        end else if (w_rearm && (r_state == ST_CAPT || r_state == ST_DONE)) begin
          // Re-arm wins over a coincident trigger; that edge is dropped.
          w_next_state = ST_ARMED;
          w_next_ptr   = '0;
          w_next_done  = 1'b0;
        end else begin
          case (r_state)
            ST_ARMED: begin
              if (w_trig) begin
                w_we         = 1'b1;
                w_next_ptr   = PTR_W'(1);
                w_next_state = ST_CAPT;
              end
            end
            ST_CAPT: begin
              if (w_strobe) begin
                w_we = 1'b1;
                if (w_ptr_last) begin
                  w_next_state = ST_DONE;
                  w_next_ptr   = '0;
                  w_next_done  = 1'b1;
                end else begin
                  w_next_ptr = w_ptr_inc;
                end
              end
            end
            default: ;  // ST_DONE: buffer frozen, done held
          endcase
        end
      end

      MODE_HOLD: begin
        w_next_state = ST_HOLD;
        w_next_done  = 1'b0;
      end

      default: begin  // MODE_CLR
        w_next_state = ST_CLR;
        w_next_ptr   = '0;
        w_next_done  = 1'b0;
        w_clr        = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wave      <= '0;
      r_wr_ptr    <= '0;
      r_prev_trig <= 1'b0;
      r_sw3_d     <= 1'b0;
      r_done      <= 1'b0;
      r_capturing <= 1'b0;
      r_state     <= mode_entry_state(w_mode);
    end else begin
      r_state     <= w_next_state;
      r_wr_ptr    <= w_next_ptr;
      r_done      <= w_next_done;
      r_capturing <= (w_next_state == ST_ARMED) || (w_next_state == ST_CAPT);
      r_sw3_d     <= i_sw[3];
      if (w_strobe) r_prev_trig <= i_sample_in[0];
      if (w_clr) begin
        r_wave <= '0;
      end else begin
        for (int k = 0; k < DEPTH; k++) begin
          if (w_we && (r_wr_ptr == PTR_W'(k))) r_wave[k*CH +: CH] <= i_sample_in;
        end
      end
    end
  end

  assign o_wave_form = r_wave;
  assign o_wr_ptr    = r_wr_ptr;
  assign o_done      = r_done;
  assign o_capturing = r_capturing;

endmodule

// File: tb/tb_wave_capture.sv
module tb_wave_capture;

  logic        clk;
  logic        rst;
  logic [3:0]  sw;
  logic [0:0]  smp;
  logic [7:0]  div;
  logic [19:0] wave;
  logic [4:0]  ptr;
  logic        cap;
  logic        done;

  logic        rst2;
  logic [3:0]  sw2;
  logic [1:0]  smp2;
  logic [7:0]  div2;
  logic [15:0] wave2;
  logic [2:0]  ptr2;
  logic        cap2;
  logic        done2;

  int n_checks = 0;
  int n_errors = 0;

  wave_capture u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_sw        (sw),
    .i_sample_in (smp),
    .i_div       (div),
    .o_wave_form (wave),
    .o_wr_ptr    (ptr),
    .o_capturing (cap),
    .o_done      (done)
  );

  wave_capture #(.DEPTH(8), .CH(2), .DIV_W(8)) u_dut2 (
    .i_clk       (clk),
    .i_rst       (rst2),
    .i_sw        (sw2),
    .i_sample_in (smp2),
    .i_div       (div2),
    .o_wave_form (wave2),
    .o_wr_ptr    (ptr2),
    .o_capturing (cap2),
    .o_done      (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; sw = 4'b0000; smp = 1'b0; div = 8'd0;
    rst2 = 1'b1; sw2 = 4'b0001; smp2 = 2'b00; div2 = 8'd0;
    tick(2);
    chk("rst_wave", 32'(wave), 32'h0);
    chk("rst_ptr",  32'(ptr),  32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_cap",  32'(cap),  32'h0);

    // 1: run mode, strobe every clock, alternating 1,0,... from slot 0
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      smp = (k % 2 == 0) ? 1'b1 : 1'b0;
      tick(1);
      if (k == 18) chk("t1_ptr19", 32'(ptr), 32'd19);
    end
    chk("t1_wave", 32'(wave), 32'h55555);
    chk("t1_wrap", 32'(ptr),  32'd0);

    // 2: run mode, div=3 -> one write per 4 clocks
    rst = 1'b1; div = 8'd3; smp = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(39);
    chk("t2_ptr39", 32'(ptr), 32'd9);
    tick(1);
    chk("t2_ptr40", 32'(ptr),  32'd10);
    chk("t2_wave",  32'(wave), 32'h003FF);

    // 3: single shot, rising trigger after 5 low strobes
    rst = 1'b1; sw = 4'b0001; div = 8'd0; smp = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("t3_armed_cap", 32'(cap),  32'h1);
    chk("t3_armed_ptr", 32'(ptr),  32'd0);
    chk("t3_armed_wav", 32'(wave), 32'h0);
    smp = 1'b1;
    tick(19);
    chk("t3_ptr19",  32'(ptr),  32'd19);
    chk("t3_done0",  32'(done), 32'h0);
    chk("t3_wave19", 32'(wave), 32'h7FFFF);
    tick(1);
    chk("t3_done1", 32'(done), 32'h1);
    chk("t3_ptr0",  32'(ptr),  32'd0);
    chk("t3_wave",  32'(wave), 32'hFFFFF);
    chk("t3_cap0",  32'(cap),  32'h0);
    for (int i = 0; i < 4; i++) begin
      smp = (i % 2 == 1) ? 1'b1 : 1'b0;
      tick(1);
    end
    chk("t3_frozen", 32'(wave), 32'hFFFFF);
    chk("t3_held",   32'(done), 32'h1);

    // 4: re-arm with a coincident trigger edge; the edge is ignored
    smp = 1'b0; sw = 4'b0001;
    tick(1);
    sw = 4'b1001; smp = 1'b1;
    tick(1);
    chk("t4_done", 32'(done), 32'h0);
    chk("t4_ptr",  32'(ptr),  32'd0);
    chk("t4_cap",  32'(cap),  32'h1);
    chk("t4_wave", 32'(wave), 32'hFFFFF);
    tick(3);
    chk("t4_no_trig", 32'(ptr), 32'd0);
    smp = 1'b0;
    tick(1);
    smp = 1'b1;
    tick(1);
    chk("t4_trig_ptr", 32'(ptr), 32'd1);
    smp = 1'b0;
    tick(3);
    chk("t4_capt_ptr",  32'(ptr),  32'd4);
    chk("t4_capt_wave", 32'(wave), 32'hFFFF1);

    // 5: abandon capture into run, then hold, then clear
    sw = 4'b0000; smp = 1'b1;
    tick(1);
    chk("t5_run_ptr",  32'(ptr),  32'd5);
    chk("t5_run_done", 32'(done), 32'h0);
    chk("t5_run_cap",  32'(cap),  32'h0);
    smp = 1'b0;
    tick(3);
    chk("t5_run_wave", 32'(wave), 32'hFFF11);
    chk("t5_run_ptr8", 32'(ptr),  32'd8);
    sw = 4'b0010; smp = 1'b1;
    tick(25);
    chk("t5_hold_wave_a", 32'(wave), 32'hFFF11);
    chk("t5_hold_ptr_a",  32'(ptr),  32'd8);
    smp = 1'b0;
    tick(25);
    chk("t5_hold_wave_b", 32'(wave), 32'hFFF11);
    chk("t5_hold_ptr_b",  32'(ptr),  32'd8);
    sw = 4'b0011;
    tick(1);
    chk("t5_clr_wave", 32'(wave), 32'h0);
    chk("t5_clr_ptr",  32'(ptr),  32'd0);

    // 6: CH=2, DEPTH=8; reset mid-capture at wr_ptr=5
    rst2 = 1'b0;
    tick(1);
    chk("t6_cap_armed", 32'(cap2), 32'h1);
    smp2 = 2'b11; tick(1);
    smp2 = 2'b10; tick(1);
    smp2 = 2'b01; tick(1);
    smp2 = 2'b10; tick(1);
    smp2 = 2'b11; tick(1);
    chk("t6_ptr5", 32'(ptr2),  32'd5);
    chk("t6_wave", 32'(wave2), 32'h039B);
    rst2 = 1'b1;
    tick(1);
    chk("t6_rst_wave", 32'(wave2), 32'h0);
    chk("t6_rst_ptr",  32'(ptr2),  32'd0);
    chk("t6_rst_done", 32'(done2), 32'h0);
    chk("t6_rst_cap",  32'(cap2),  32'h0);
    rst2 = 1'b0;
    tick(1);
    chk("t6_retrig_ptr",  32'(ptr2),  32'd1);
    chk("t6_retrig_wave", 32'(wave2), 32'h0003);
    chk("t6_retrig_cap",  32'(cap2),  32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
